// File: rtl/egress_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : egress_frame_reader
// Purpose  : Drains the read side of an async FIFO holding {last, data} words
//            and presents them as a valid/ready byte stream. A 2-entry output
//            buffer hides the FIFO's 1-cycle read latency so that one beat per
//            cycle is sustained. Frames longer than MAX_LEN beats are cut at
//            beat MAX_LEN (flagged with m_err on that last beat) and the rest
//            of the oversized frame is discarded.
// Ports    : rclk, rrst_n          read-domain clock, async active-low reset
//            fifo_r_en             read strobe to the FIFO
//            fifo_r_data           {last, data}, valid the cycle after fifo_r_en
//            fifo_r_empty          FIFO empty flag
//            m_valid/m_ready       output stream handshake
//            m_data/m_last/m_err   output beat, end of frame, truncated frame
//            frame_cnt             frames delivered (wrapping)
//            trunc_cnt             frames truncated (wrapping)
// Revision : 1.0  initial release
// ============================================================================
module egress_frame_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 1518,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   output logic                  fifo_r_en,
   input  logic [DATA_WIDTH:0]   fifo_r_data,
   input  logic                  fifo_r_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  m_err,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  trunc_cnt
);

   localparam int                 c_LEN_W     = $clog2(MAX_LEN + 1);
   localparam int                 c_ENT_W     = DATA_WIDTH + 2;   // {err, last, data}
   localparam logic [c_LEN_W-1:0] c_LEN_LIMIT = c_LEN_W'(MAX_LEN - 1);

   typedef enum logic [0:0] {
      ST_PASS = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_pending;
   logic [c_LEN_W-1:0]      r_len, w_len_nxt;
   logic [c_ENT_W-1:0]      r_mem [2];
   logic                    r_wr_ptr, r_rd_ptr;
   logic [1:0]              r_count;
   logic                    w_pop, w_push, w_trunc, w_drop_free;
   logic [c_ENT_W-1:0]      w_push_word;
   logic [2:0]              w_occ;
   logic                    w_in_last;
   logic [DATA_WIDTH-1:0]   w_in_data;

   assign w_in_last = fifo_r_data[DATA_WIDTH];
   assign w_in_data = fifo_r_data[DATA_WIDTH-1:0];

   assign m_valid = (r_count != 2'd0);
   assign {m_err, m_last, m_data} = r_mem[r_rd_ptr];
   assign w_pop   = m_valid && m_ready;

   // Buffer occupancy once every in-flight word has landed and this cycle's
   // pop has left; a new read is only issued if there is room for its word.
   assign w_occ = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};

   // While dropping, reads free-run, except when the word now being consumed
   // closes the dropped frame: the next word then belongs to a new frame and
   // will be pushed, so it has to go through the occupancy check.
   assign w_drop_free = (r_state == ST_DROP) && !(r_pending && w_in_last);

   assign fifo_r_en = rrst_n && !fifo_r_empty && (w_drop_free || (w_occ < 3'd2));

   // ------------------------------------------------------------------------
   // Frame state machine: next state, length tracking, push decision
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_push      = 1'b0;
      w_trunc     = 1'b0;
      w_push_word = {1'b0, w_in_last, w_in_data};
      if (r_pending) begin
         case (r_state)
            ST_PASS: begin
               w_push = 1'b1;
               if (w_in_last) begin
                  w_len_nxt = '0;
               end else if (r_len == c_LEN_LIMIT) begin
                  // Beat MAX_LEN of an oversized frame: close it with an error.
                  w_push_word = {1'b1, 1'b1, w_in_data};
                  w_trunc     = 1'b1;
                  w_len_nxt   = '0;
                  w_state_nxt = ST_DROP;
               end else begin
                  w_len_nxt = r_len + c_LEN_W'(1);
               end
            end
            ST_DROP: begin
               if (w_in_last) begin
                  w_state_nxt = ST_PASS;
               end
            end
            default: w_state_nxt = ST_PASS;
         endcase
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state <= ST_PASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Read tracking, output buffer and statistics
   // ------------------------------------------------------------------------
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_pending <= 1'b0;
         r_len     <= '0;
         r_mem[0]  <= '0;
         r_mem[1]  <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
         frame_cnt <= '0;
         trunc_cnt <= '0;
      end else begin
         r_pending <= fifo_r_en;
         r_len     <= w_len_nxt;
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (w_pop && m_last) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         end
         if (w_trunc) begin
            trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
         end
      end
   end

   a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
      !(w_push && (r_count == 2'd2) && !w_pop));

   a_no_read_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
      !(fifo_r_en && fifo_r_empty));

endmodule
`default_nettype wire
